// File: rtl/pid_controller.sv
// pid_controller
//
// PID update engine for the motor-control path. A free-running tick counter
// starts one update every UPDATE_DIVIDER clocks. Each update snapshots all
// inputs, forms the error for the selected mode, and evaluates P, I and D
// terms on one shared 24x24 multiplier. It then sums and clamps the terms
// into the signed pwm word.
//
// Optional feature macro: PID_DERIVATIVE_EN
//   defined   -> DTERM state, prev_error register and d term are present
//   undefined -> no DTERM state, Kd ignored, update is one cycle shorter
//
// Ports
//   CLK                system clock
//   reset_n            asynchronous active-low reset
//   control_mode[7:0]  0 position, 1 velocity, 2 displacement, 3 direct, else off
//   setpoint           signed 24-bit target
//   encoder0_position  signed 24-bit encoder count
//   displacement       signed 24-bit spring displacement
//   Kp, Ki, Kd         signed 24-bit integer gains
//   PWMLimit           unsigned 24-bit output magnitude limit
//   IntegralLimit      unsigned 24-bit integrator magnitude limit
//   deadband           unsigned 24-bit error magnitude treated as zero
//   pwm                signed 24-bit control output (held between updates)
//   update_done        one-cycle pulse when pwm takes a new value
//
// state  | meaning
// IDLE   | wait for tick counter wrap
// LATCH  | snapshot all inputs
// ERROR  | mode-dependent error, saturation, deadband
// PTERM  | p = Kp * error
// ITERM  | integrate and clamp, i = Ki * integral
// DTERM  | d = Kd * (error - prev_error)   (PID_DERIVATIVE_EN only)
// SUM    | s = p + i + d (or direct setpoint in mode 3)
// OUTPUT | clamp s into pwm, pulse update_done

module pid_controller #(
    parameter int UPDATE_DIVIDER = 1000
) (
    input  logic               CLK,
    input  logic               reset_n,
    input  logic [7:0]         control_mode,
    input  logic signed [23:0] setpoint,
    input  logic signed [23:0] encoder0_position,
    input  logic signed [23:0] displacement,
    input  logic signed [23:0] Kp,
    input  logic signed [23:0] Ki,
    input  logic signed [23:0] Kd,
    input  logic [23:0]        PWMLimit,
    input  logic [23:0]        IntegralLimit,
    input  logic [23:0]        deadband,
    output logic signed [23:0] pwm,
    output logic               update_done
);

    localparam int CW = $clog2(UPDATE_DIVIDER);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_ERROR  = 3'd2,
        S_PTERM  = 3'd3,
        S_ITERM  = 3'd4,
`ifdef PID_DERIVATIVE_EN
        S_DTERM  = 3'd5,
`endif
        S_SUM    = 3'd6,
        S_OUTPUT = 3'd7
    } state_t;

    state_t state, next_state;

    function automatic logic signed [23:0] sat24(input logic signed [25:0] x);
        if (x > 26'sd8388607)
            return 24'sh7FFFFF;
        else if (x < -26'sd8388608)
            return 24'sh800000;
        return x[23:0];
    endfunction

    // Limits above 2^23-1 cannot be represented as a positive signed word.
    function automatic logic [23:0] cap_limit(input logic [23:0] x);
        return (x > 24'h7FFFFF) ? 24'h7FFFFF : x;
    endfunction

    // ---------------- tick counter ----------------
    logic [CW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == CW'(UPDATE_DIVIDER - 1));

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (tick) next_state = S_LATCH;
            S_LATCH:  next_state = S_ERROR;
            S_ERROR:  next_state = S_PTERM;
            S_PTERM:  next_state = S_ITERM;
`ifdef PID_DERIVATIVE_EN
            S_ITERM:  next_state = S_DTERM;
            S_DTERM:  next_state = S_SUM;
`else
            S_ITERM:  next_state = S_SUM;
`endif
            S_SUM:    next_state = S_OUTPUT;
            S_OUTPUT: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // ---------------- snapshot and datapath registers ----------------
    logic [7:0]         s_mode;
    logic signed [23:0] s_set, s_enc, s_disp, s_kp, s_ki;
    logic [23:0]        s_plim, s_ilim, s_db;
    logic [7:0]         last_mode;
    logic               mode_chg;
    logic signed [23:0] enc_prev;
    logic signed [23:0] err;
    logic signed [23:0] integral;
    logic signed [47:0] p_term, i_term, d_term;
    logic signed [49:0] sum_term;

`ifdef PID_DERIVATIVE_EN
    logic signed [23:0] s_kd;
    logic signed [23:0] prev_error;
    logic signed [23:0] prev_base;
    logic signed [25:0] d_raw;
    logic signed [23:0] d_diff;
`else
    logic unused_kd;
    assign unused_kd = ^Kd;
`endif

    logic loop_mode, direct_mode;
    assign loop_mode   = (s_mode <= 8'd2);
    assign direct_mode = (s_mode == 8'd3);

    // Error formation: 26-bit intermediate covers the velocity path, where
    // the encoder delta itself can already need 25 bits.
    logic signed [25:0] err_raw;
    logic signed [23:0] err_sat;
    logic [23:0]        err_mag;
    logic signed [23:0] err_db;

    always_comb begin
        err_raw = '0;
        case (s_mode)
            8'd0:    err_raw = s_set - s_enc;
            8'd1:    err_raw = s_set - (s_enc - enc_prev);
            8'd2:    err_raw = s_set - s_disp;
            default: err_raw = '0;
        endcase
        err_sat = sat24(err_raw);
        err_mag = err_sat[23] ? 24'(-err_sat) : err_sat;
        err_db  = (err_mag <= s_db) ? 24'sd0 : err_sat;
    end

    // Integrator: a mode change restarts accumulation from zero.
    logic signed [23:0] integ_base;
    logic signed [24:0] integ_sum, ilim_s, ilim_neg;
    logic signed [23:0] integ_next;

    always_comb begin
        integ_base = mode_chg ? 24'sd0 : integral;
        integ_sum  = integ_base + err;
        ilim_s     = $signed({1'b0, s_ilim});
        ilim_neg   = -ilim_s;
        integ_next = '0;
        if (loop_mode) begin
            if (integ_sum > ilim_s)
                integ_next = ilim_s[23:0];
            else if (integ_sum < ilim_neg)
                integ_next = ilim_neg[23:0];
            else
                integ_next = integ_sum[23:0];
        end
    end

`ifdef PID_DERIVATIVE_EN
    always_comb begin
        prev_base = mode_chg ? 24'sd0 : prev_error;
        d_raw     = err - prev_base;
        d_diff    = sat24(d_raw);
    end
`endif

    // Shared multiplier, operands steered by state.
    logic signed [23:0] mult_a, mult_b;
    logic signed [47:0] product;

    always_comb begin
        mult_a = s_kp;
        mult_b = err;
        case (state)
            S_ITERM: begin
                mult_a = s_ki;
                mult_b = integ_next;
            end
`ifdef PID_DERIVATIVE_EN
            S_DTERM: begin
                mult_a = s_kd;
                mult_b = d_diff;
            end
`endif
            default: ;
        endcase
    end

    assign product = mult_a * mult_b;

    logic signed [49:0] plim_s, plim_neg;
    assign plim_s   = $signed({26'd0, s_plim});
    assign plim_neg = -plim_s;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            s_mode      <= '0;
            s_set       <= '0;
            s_enc       <= '0;
            s_disp      <= '0;
            s_kp        <= '0;
            s_ki        <= '0;
            s_plim      <= '0;
            s_ilim      <= '0;
            s_db        <= '0;
            last_mode   <= 8'hFF;
            mode_chg    <= 1'b0;
            enc_prev    <= '0;
            err         <= '0;
            integral    <= '0;
            p_term      <= '0;
            i_term      <= '0;
            d_term      <= '0;
            sum_term    <= '0;
            pwm         <= '0;
            update_done <= 1'b0;
`ifdef PID_DERIVATIVE_EN
            s_kd        <= '0;
            prev_error  <= '0;
`endif
        end else begin
            update_done <= 1'b0;
            case (state)
                S_LATCH: begin
                    s_mode <= control_mode;
                    s_set  <= setpoint;
                    s_enc  <= encoder0_position;
                    s_disp <= displacement;
                    s_kp   <= Kp;
                    s_ki   <= Ki;
                    s_plim <= cap_limit(PWMLimit);
                    s_ilim <= cap_limit(IntegralLimit);
                    s_db   <= deadband;
`ifdef PID_DERIVATIVE_EN
                    s_kd   <= Kd;
`endif
                end
                S_ERROR: begin
                    err       <= err_db;
                    enc_prev  <= s_enc;
                    mode_chg  <= (s_mode != last_mode);
                    last_mode <= s_mode;
                end
                S_PTERM: p_term <= product;
                S_ITERM: begin
                    integral <= integ_next;
                    i_term   <= product;
                end
`ifdef PID_DERIVATIVE_EN
                S_DTERM: begin
                    d_term     <= product;
                    prev_error <= err;
                end
`endif
                S_SUM: begin
                    if (direct_mode)
                        sum_term <= s_set;
                    else if (loop_mode)
                        sum_term <= p_term + i_term + d_term;
                    else
                        sum_term <= '0;
                end
                S_OUTPUT: begin
                    if (sum_term > plim_s)
                        pwm <= plim_s[23:0];
                    else if (sum_term < plim_neg)
                        pwm <= plim_neg[23:0];
                    else
                        pwm <= sum_term[23:0];
                    update_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_controller.sv
module tb_pid_controller;

    localparam int DIV = 16;
`ifdef PID_DERIVATIVE_EN
    localparam int LAT = 23;
    localparam int ABORT_WAIT = 11;
`else
    localparam int LAT = 22;
    localparam int ABORT_WAIT = 12;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic [7:0]         control_mode;
    logic signed [23:0] setpoint, encoder0_position, displacement;
    logic signed [23:0] Kp, Ki, Kd;
    logic [23:0]        PWMLimit, IntegralLimit, deadband;
    logic signed [23:0] pwm;
    logic               update_done;

    always #5 clk = ~clk;

    pid_controller #(.UPDATE_DIVIDER(DIV)) dut (
        .CLK               (clk),
        .reset_n           (rst_n),
        .control_mode      (control_mode),
        .setpoint          (setpoint),
        .encoder0_position (encoder0_position),
        .displacement      (displacement),
        .Kp                (Kp),
        .Ki                (Ki),
        .Kd                (Kd),
        .PWMLimit          (PWMLimit),
        .IntegralLimit     (IntegralLimit),
        .deadband          (deadband),
        .pwm               (pwm),
        .update_done       (update_done)
    );

    typedef struct {
        int mode, sp, enc, disp, kp, ki, kd, plim, ilim, db;
        int exp_d;   // expected pwm with derivative enabled
        int exp_nd;  // expected pwm without derivative
    } vec_t;

    vec_t vecs[$];
    int errors = 0;
    int checks = 0;

    task automatic add(input int mode, input int sp, input int enc, input int disp,
                       input int kp, input int ki, input int kd, input int plim,
                       input int ilim, input int db, input int exp_d, input int exp_nd);
        vec_t v;
        v.mode = mode; v.sp = sp; v.enc = enc; v.disp = disp;
        v.kp = kp; v.ki = ki; v.kd = kd;
        v.plim = plim; v.ilim = ilim; v.db = db;
        v.exp_d = exp_d; v.exp_nd = exp_nd;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_done(input string name, output int cycles);
        bit ok;
        ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (update_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no update_done in 64 cycles, expected a pulse", name);
        end
    endtask

    task automatic apply(input vec_t v);
        control_mode      = 8'(v.mode);
        setpoint          = 24'(v.sp);
        encoder0_position = 24'(v.enc);
        displacement      = 24'(v.disp);
        Kp                = 24'(v.kp);
        Ki                = 24'(v.ki);
        Kd                = 24'(v.kd);
        PWMLimit          = 24'(v.plim);
        IntegralLimit     = 24'(v.ilim);
        deadband          = 24'(v.db);
    endtask

    initial begin
        int cyc;
        int bad;
        int exp;

        //   mode sp        enc       disp kp ki kd plim      ilim  db  exp_d    exp_nd
        add(0,   100,      40,       0,   2, 0, 0, 500,      1000, 0,  120,     120);
        add(0,   100,      40,       0,   2, 0, 0, 50,       1000, 0,  50,      50);
        add(0,   -100,     40,       0,   2, 0, 0, 50,       1000, 0,  -50,     -50);
        add(4,   100,      40,       0,   2, 0, 0, 50,       1000, 0,  0,       0);
        add(0,   10,       0,        0,   0, 1, 0, 500,      25,   0,  10,      10);
        add(0,   10,       0,        0,   0, 1, 0, 500,      25,   0,  20,      20);
        add(0,   10,       0,        0,   0, 1, 0, 500,      25,   0,  25,      25);
        add(0,   10,       0,        0,   0, 1, 0, 500,      25,   0,  25,      25);
        add(0,   5,        0,        0,   3, 1, 0, 500,      100,  5,  25,      25);
        add(0,   6,        0,        0,   3, 0, 0, 500,      100,  5,  18,      18);
        add(0,   -5,       0,        0,   3, 0, 0, 500,      100,  5,  0,       0);
        add(0,   -6,       0,        0,   3, 0, 0, 500,      100,  5,  -18,     -18);
        add(0,   0,        0,        0,   0, 0, 4, 500,      100,  0,  24,      0);
        add(0,   0,        0,        0,   0, 0, 4, 500,      100,  0,  0,       0);
        add(0,   10,       0,        0,   0, 0, 4, 500,      100,  0,  40,      0);
        add(0,   10,       0,        0,   0, 0, 4, 500,      100,  0,  0,       0);
        add(5,   10,       0,        0,   0, 0, 0, 500,      1000, 0,  0,       0);
        add(0,   20,       0,        0,   0, 1, 0, 500,      1000, 0,  20,      20);
        add(2,   7,        0,        0,   0, 1, 0, 500,      1000, 0,  7,       7);
        add(2,   7,        0,        2,   0, 1, 0, 500,      1000, 0,  12,      12);
        add(1,   0,        30,       0,   1, 0, 0, 500,      1000, 0,  -30,     -30);
        add(1,   25,       50,       0,   1, 0, 0, 500,      1000, 0,  5,       5);
        add(3,   -1000,    50,       0,   1, 0, 0, 128,      1000, 0,  -128,    -128);
        add(3,   100,      50,       0,   1, 0, 0, 128,      1000, 0,  100,     100);
        add(0,   8388607,  -8388608, 0,   1, 0, 0, 16777215, 1000, 0,  8388607, 8388607);
        add(0,   -8388608, 8388607,  0,   1, 0, 0, 16777215, 1000, 0,  -8388607, -8388607);

        // Reset hold with direct mode inputs already present.
        rst_n = 1'b0;
        control_mode = 8'd3; setpoint = 24'sd70; encoder0_position = '0; displacement = '0;
        Kp = '0; Ki = '0; Kd = '0;
        PWMLimit = 24'd128; IntegralLimit = 24'd1000; deadband = '0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (update_done !== 1'b0 || pwm !== 24'sd0) bad++;
        end
        check("reset_hold_outputs", bad, 0);
        rst_n = 1'b1;
        wait_done("first_update", cyc);
        check("first_update_latency", cyc, LAT);
        check("first_update_pwm", int'(pwm), 70);
        @(posedge clk);
        #1;
        check("done_single_cycle", int'(update_done), 0);

        foreach (vecs[i]) begin
            apply(vecs[i]);
            wait_done($sformatf("vec%0d", i), cyc);
`ifdef PID_DERIVATIVE_EN
            exp = vecs[i].exp_d;
`else
            exp = vecs[i].exp_nd;
`endif
            check($sformatf("vec%0d_pwm", i), int'(pwm), exp);
        end

        // Reset in the middle of an update (around T+3) aborts it.
        control_mode = 8'd3; setpoint = 24'sd70; PWMLimit = 24'd128;
        repeat (ABORT_WAIT) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_pwm_cleared", int'(pwm), 0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (update_done !== 1'b0) bad++;
        end
        check("abort_no_done_in_reset", bad, 0);
        rst_n = 1'b1;
        wait_done("post_abort", cyc);
        check("post_abort_latency", cyc, LAT);
        check("post_abort_pwm", int'(pwm), 70);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
